// File: rtl/spi_display_tx.sv
// spi_display_tx: byte-level SPI mode-0 master for the display, with power-on reset sequencing.
//   clk, rst                  : single clock, synchronous active-high reset
//   i_valid/i_ready/i_data/i_dc : byte + data/command select from the MMU (valid/ready)
//   o_valid/o_data            : one-cycle pulse with the byte received on spi_miso
//   busy                      : high whenever not IDLE
//   display_rstb/display_csb/data_commandb/spi_clk/spi_mosi/spi_miso : display pins
module spi_display_tx #(
    parameter int CLK_DIV      = 4,
    parameter int RESET_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    output logic       i_ready,
    input  logic [7:0] i_data,
    input  logic       i_dc,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       busy,
    output logic       display_rstb,
    output logic       display_csb,
    output logic       data_commandb,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso
);
    localparam int HW = $clog2(CLK_DIV) + 1;
    localparam int RW = $clog2(RESET_CYCLES) + 1;

    typedef enum logic [2:0] {RST_LOW, RST_WAIT, IDLE, SHIFT, DONE} state_t;

    state_t        r_state, w_next;
    logic [HW-1:0] r_half;
    logic [RW-1:0] r_rcnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_tx, r_rx, r_odata;
    logic          r_sclk, r_dc;
    logic          w_rst_done, w_edge, w_rise, w_fall, w_accept, w_trans, w_shift;

    assign w_rst_done = r_rcnt == RW'(RESET_CYCLES - 1);
    assign w_edge     = r_half == HW'(CLK_DIV - 1);
    assign w_shift    = r_state == SHIFT;
    assign w_rise     = w_shift & w_edge & ~r_sclk;
    assign w_fall     = w_shift & w_edge & r_sclk;
    assign w_accept   = (r_state == IDLE) & i_valid;
    assign w_trans    = w_next != r_state;

    always_ff @(posedge clk) begin
        if (rst) r_state <= RST_LOW;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            RST_LOW:  w_next = w_rst_done ? RST_WAIT : RST_LOW;
            RST_WAIT: w_next = w_rst_done ? IDLE : RST_WAIT;
            IDLE:     w_next = i_valid ? SHIFT : IDLE;
            SHIFT:    w_next = (w_fall && r_bit == 3'd7) ? DONE : SHIFT;
            DONE:     w_next = IDLE;
            default:  w_next = RST_LOW;
        endcase
        i_ready       = r_state == IDLE;
        busy          = r_state != IDLE;
        o_valid       = r_state == DONE;
        display_rstb  = r_state != RST_LOW;
        display_csb   = r_state != SHIFT;
        o_data        = r_odata;
        data_commandb = r_dc;
        spi_clk       = r_sclk;
        spi_mosi      = r_tx[7];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_half  <= '0;
            r_rcnt  <= '0;
            r_bit   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_odata <= '0;
            r_sclk  <= 1'b0;
            r_dc    <= 1'b0;
        end else begin
            // Both counters restart on any state change; outside their own states the values are don't-care.
            r_rcnt <= w_trans ? '0 : r_rcnt + RW'(1);
            r_half <= (w_trans || w_edge) ? '0 : r_half + HW'(1);
            r_sclk <= w_shift & (r_sclk ^ w_edge);
            if (w_accept) begin
                r_tx  <= i_data;
                r_dc  <= i_dc;
                r_bit <= '0;
            end else if (w_fall) begin
                r_tx  <= {r_tx[6:0], 1'b0};
                r_bit <= r_bit + 3'd1;
            end
            if (w_rise) r_rx <= {r_rx[6:0], spi_miso};
            // The final bit was captured on the preceding rising edge, so r_rx is complete here.
            if (w_shift && w_next == DONE) r_odata <= r_rx;
        end
    end
endmodule

// File: tb/tb_spi_display_tx.sv
// tb_spi_display_tx: scoreboard bench for spi_display_tx (reset sequence, frames, loopback, aborts).
module tb_spi_display_tx;
    localparam int D  = 2;
    localparam int RC = 16;

    logic       clk = 1'b0, rst = 1'b1, i_valid = 1'b0, i_dc = 1'b0, loop = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_ready, o_valid, busy, display_rstb, display_csb, data_commandb;
    logic       spi_clk, spi_mosi, spi_miso;
    logic [7:0] o_data;

    spi_display_tx #(.CLK_DIV(D), .RESET_CYCLES(RC)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_dc(i_dc),
        .o_valid(o_valid), .o_data(o_data), .busy(busy), .display_rstb(display_rstb),
        .display_csb(display_csb), .data_commandb(data_commandb), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_err = 0;
    logic [7:0] exp_rx[$];
    logic [8:0] exp_tx[$];
    logic [7:0] resp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Display-side responder: loads a reply byte at frame start, advances on each spi_clk fall.
    logic [7:0] slave = 8'h00;
    logic       s_prev_csb = 1'b1, s_prev_sclk = 1'b0;
    assign spi_miso = loop ? spi_mosi : slave[7];
    always @(negedge clk) begin
        if (!display_csb && s_prev_csb) slave <= (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
        else if (!spi_clk && s_prev_sclk) slave <= {slave[6:0], 1'b0};
        s_prev_csb  <= display_csb;
        s_prev_sclk <= spi_clk;
    end

    // Monitor: frame observer on the pins plus o_valid scoreboard.
    int         frames = 0, last_gap = 0, hi_len = 0, low_len = 0, rises = 0;
    logic [7:0] cap = 8'h00;
    logic [8:0] e;
    logic       frame_dc = 1'b0, prev_csb = 1'b1, prev_sclk = 1'b0, prev_dc = 1'b0;
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            if (exp_rx.size() == 0) check("unexpected_o_valid", 1, 0);
            else check("o_data", o_data, exp_rx.pop_front());
        end
        if (data_commandb !== prev_dc) check("dc_change_while_csb_high", prev_csb, 1);
        if (!display_csb && prev_csb) begin
            last_gap = hi_len;
            low_len  = 1;
            rises    = 0;
            cap      = 8'h00;
            frame_dc = data_commandb;
        end else if (!display_csb) begin
            low_len++;
            if (spi_clk && !prev_sclk) begin
                cap = {cap[6:0], spi_mosi};
                rises++;
            end
        end
        if (display_csb) hi_len = prev_csb ? hi_len + 1 : 1;
        if (display_csb && !prev_csb && display_rstb) begin
            frames++;
            if (exp_tx.size() == 0) check("unexpected_frame", 1, 0);
            else begin
                e = exp_tx.pop_front();
                check("mosi_byte", cap, e[7:0]);
                check("frame_dc", frame_dc, e[8]);
                check("rising_edges", rises, 8);
                check("csb_low_cycles", low_len, 16 * D);
            end
        end
        prev_csb  = display_csb;
        prev_sclk = spi_clk;
        prev_dc   = data_commandb;
    end

    task automatic send(input logic [7:0] d, input logic dc, input logic [7:0] r, input logic done);
        int k = 0;
        resp_q.push_back(r);
        if (done) begin
            exp_tx.push_back({dc, d});
            exp_rx.push_back(loop ? d : r);
        end
        i_valid = 1'b1;
        i_data  = d;
        i_dc    = dc;
        while (i_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("accept_timeout", 0, 1);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (i_ready !== 1'b1 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) check("idle_timeout", 0, 1);
    endtask

    int n, bad;
    initial begin
        repeat (3) @(negedge clk);
        check("rst_rstb", display_rstb, 0);
        check("rst_csb", display_csb, 1);
        check("rst_sclk", spi_clk, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_dc", data_commandb, 0);
        check("rst_ready", i_ready, 0);
        check("rst_ovalid", o_valid, 0);
        check("rst_odata", o_data, 0);
        check("rst_busy", busy, 1);
        rst = 1'b0;
        n = 0;
        bad = 0;
        while (display_rstb !== 1'b1 && n < 200) begin
            n++;
            if (display_csb !== 1'b1 || spi_clk !== 1'b0) bad++;
            @(negedge clk);
        end
        check("rstb_low_cycles", n, RC);
        n = 0;
        while (i_ready !== 1'b1 && n < 200) begin
            n++;
            if (display_csb !== 1'b1 || spi_clk !== 1'b0 || display_rstb !== 1'b1) bad++;
            @(negedge clk);
        end
        check("settle_cycles", n, RC);
        check("pins_quiet_in_reset", bad, 0);
        check("idle_busy", busy, 0);

        send(8'hA5, 1'b1, 8'h96, 1'b1);
        check("dc_from_cycle1", data_commandb, 1);
        check("csb_low_cycle1", display_csb, 0);
        check("mosi_bit7_cycle1", spi_mosi, 1);
        wait_idle();

        loop = 1'b1;
        send(8'h3C, 1'b0, 8'h00, 1'b1);
        n = 1;
        while (o_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("o_valid_cycle", n, 16 * D + 1);
        @(negedge clk);
        check("o_valid_width", o_valid, 0);
        repeat (5) @(negedge clk);
        check("o_data_held", o_data, 8'h3C);
        wait_idle();
        loop = 1'b0;

        send(8'h2A, 1'b0, 8'h11, 1'b1);
        send(8'h00, 1'b1, 8'hEE, 1'b1);
        repeat (5) @(negedge clk);
        check("b2b_csb_gap", last_gap, 2);
        wait_idle();

        send(8'h5A, 1'b1, 8'hC3, 1'b1);
        repeat (4) @(negedge clk);
        i_valid = 1'b1;
        i_data  = 8'h77;
        i_dc    = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);
        check("frames_after_busy_drop", frames, 5);

        send(8'hFF, 1'b0, 8'h55, 1'b0);
        repeat (14) @(negedge clk);
        check("bit3_sclk_high", spi_clk, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_csb", display_csb, 1);
        check("abort_sclk", spi_clk, 0);
        check("abort_rstb", display_rstb, 0);
        check("abort_ovalid", o_valid, 0);
        rst = 1'b0;
        n = 0;
        bad = 0;
        repeat (2 * RC + 5) begin
            @(negedge clk);
            if (spi_clk !== 1'b0) n++;
            if (o_valid !== 1'b0) bad++;
        end
        check("abort_no_sclk", n, 0);
        check("abort_no_ovalid", bad, 0);
        wait_idle();
        repeat (5) @(negedge clk);
        check("frames_total", frames, 5);
        check("rx_queue_empty", exp_rx.size(), 0);
        check("tx_queue_empty", exp_tx.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/spi_display_tx.md
# spi_display_tx

Byte-level SPI master that drives the system's display pins (`display_csb`, `spi_clk`, `spi_mosi`, `spi_miso`, `data_commandb`, `display_rstb`) on behalf of the MMU's display peripheral. It sits directly downstream of the MMU. The MMU hands it one command or data byte at a time over a valid/ready handshake. The block runs the power-on display reset sequence, serialises each byte in SPI mode 0 (MSB first), and returns the byte captured on `spi_miso` so the MMU can expose it as a read-back register.

## Interface
Parameters:
- `CLK_DIV`, default 4: `clk` cycles per SPI half-period. Legal range ≥1. At 61.44 MHz `clk` the default gives a 7.68 MHz `spi_clk`.
- `RESET_CYCLES`, default 1024: `clk` cycles `display_rstb` is held low after reset, and also the settle time after its release. Legal range ≥1.

Ports:
- `clk`  in  1  system clock. All logic is single-clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  MMU presents a byte.
- `i_ready`  out  1  block accepts a byte this cycle.
- `i_data`  in  8  byte to transmit.
- `i_dc`  in  1  data/command select for this byte: 1 = data, 0 = command.
- `o_valid`  out  1  one-cycle pulse; `o_data` holds the received byte.
- `o_data`  out  8  byte shifted in from `spi_miso`, held until the next pulse.
- `busy`  out  1  high in every state except IDLE.
- `display_rstb`  out  1  active-low display reset.
- `display_csb`  out  1  active-low chip select.
- `data_commandb`  out  1  registered copy of `i_dc`.
- `spi_clk`, `spi_mosi`  out  1  SPI clock and data out.
- `spi_miso`  in  1  SPI data in.

## Operation
- States: RST_LOW → RST_WAIT → IDLE → SHIFT → DONE → IDLE.
- RST_LOW:
  - `display_rstb` = 0.
  - Counts `RESET_CYCLES`, then moves to RST_WAIT.
- RST_WAIT:
  - `display_rstb` = 1.
  - Counts `RESET_CYCLES`, then moves to IDLE.
- IDLE:
  - `i_ready` = 1.
  - On `i_valid` && `i_ready`, the block latches `i_data` into the shift register and `i_dc` into `data_commandb`, clears the half-period counter and bit counter, and moves to SHIFT.
- SHIFT:
  - `display_csb` = 0.
  - `spi_mosi` = shift register bit 7 at all times.
  - `spi_clk` toggles every `CLK_DIV` cycles, starting low.
  - On each 0→1 transition of `spi_clk`, `spi_miso` is shifted into the receive register LSB-first-in, so the first bit received ends as the MSB.
  - On each 1→0 transition, the transmit register shifts left by one.
  - After the 8th falling edge the block moves to DONE.
- DONE (one cycle):
  - `display_csb` = 1.
  - `o_valid` = 1 and `o_data` = receive register.
  - Next state is IDLE.
- Every byte gets its own chip-select frame; `display_csb` is high in IDLE and DONE.
- `data_commandb` changes only on acceptance, so it is stable for the whole frame.
- `i_valid` while `i_ready` = 0 is ignored. The MMU must hold the byte until the handshake completes.
- Reset (any state, including mid-byte):
  - Next cycle: state RST_LOW, `display_rstb` 0, `display_csb` 1, `spi_clk` 0, `spi_mosi` 0, `data_commandb` 0, `i_ready` 0, `o_valid` 0, `o_data` 0x00, `busy` 1.
  - An aborted byte produces no `o_valid` pulse.
- Counters:
  - Half-period counter width is clog2(`CLK_DIV`)+1; reset counter width is clog2(`RESET_CYCLES`)+1.
  - All counters wrap to 0 on every state transition.

## Timing
- Reset sequence: after `rst` deasserts, `display_rstb` stays 0 for `RESET_CYCLES` cycles, then rises. `i_ready` rises `RESET_CYCLES` cycles after that.
- Frame timing, with acceptance at cycle 0 and D = `CLK_DIV`:
  - `display_csb` falls and `spi_mosi` = bit 7 at cycle 1.
  - `spi_clk` is high during cycles (2i+1)D+1 … (2i+2)D for bit i = 0..7.
  - The last falling edge is at cycle 16D+1.
  - DONE occurs at cycle 16D+1, with `o_valid` and `display_csb` going high.
  - The next acceptance is possible at cycle 16D+2.
- Throughput is one byte per 16D+2 cycles. Between back-to-back bytes, `display_csb` is high for exactly 2 cycles.
- `spi_miso` is sampled in the same cycle `spi_clk` goes high. The display's output must be stable from D cycles earlier.
- Outputs are registered, with no combinational path from `spi_miso` or `i_valid` to any output. `i_ready` is a pure function of state.

## Test plan
- Reset sequence: `RESET_CYCLES`=16, release `rst` at cycle 0. `display_rstb` is 0 for cycles 1–16 and 1 from cycle 17. `i_ready` rises at cycle 33. `display_csb` stays 1 and `spi_clk` stays 0 throughout.
- Transmit: D=2, send 0xA5 with `i_dc`=1. `spi_mosi` on the 8 rising edges reads 1,0,1,0,0,1,0,1. `display_csb` is low for 32 cycles. `data_commandb` is 1 from cycle 1.
- Loopback: tie `spi_miso` to `spi_mosi` and send 0x3C. `o_valid` pulses once at cycle 16D+1 with `o_data` = 0x3C. `o_data` holds 0x3C afterward.
- Back-to-back: hold `i_valid` with 0x2A/dc=0, then 0x00/dc=1. Check two frames, `display_csb` high exactly 2 cycles between them, and `data_commandb` toggling 0→1 only while `display_csb` = 1.
- Reset mid-byte: assert `rst` during bit 3 of 0xFF. Next cycle `display_csb`=1, `spi_clk`=0, `display_rstb`=0, with no `o_valid` pulse and no further `spi_clk` edges.
- Busy drop: pulse `i_valid` for one cycle while in SHIFT. The byte is not transmitted, and exactly one frame completes.
